// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with req/ack memory port and DEPTH-entry prefetch FIFO
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_queue #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [XLEN-1:0]          imem_data_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  input  logic                     freeze_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          instr_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          pcPlus4_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched_o,
  output logic [31:0]              perf_flushed_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic            push, pop;

  // Only one request may be outstanding, so "pending" is zero whenever IDLE issues.
  assign imem_req_o  = (state_q == IDLE) && (cnt_q < CW'(DEPTH)) && !redirect_i && !rst;
  assign imem_addr_o = fpc_q;
  assign push        = (state_q == WAIT) && imem_ack_i && !redirect_i;
  assign pop         = (cnt_q != '0) && !freeze_i && !redirect_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (imem_req_o) state_d = WAIT;
      WAIT:    if (imem_ack_i) state_d = IDLE;
               else if (redirect_i) state_d = DROP;
      DROP:    if (imem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fpc_d  = fpc_q;
    rptr_d = rptr_q + AW'(pop);
    wptr_d = wptr_q + AW'(push);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (redirect_i) begin
      fpc_d  = redirect_pc_i & ALIGN_MASK;
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else if (push) begin
      fpc_d  = fpc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC & ALIGN_MASK;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= fpc_q;
      instr_mem_q[wptr_q] <= imem_data_i;
    end
  end

  assign valid_o   = (cnt_q != '0);
  assign count_o   = cnt_q;
  assign pc_o      = valid_o ? pc_mem_q[rptr_q] : '0;
  assign instr_o   = valid_o ? instr_mem_q[rptr_q] : '0;
  assign pcPlus4_o = valid_o ? pc_mem_q[rptr_q] + XLEN'(4) : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;
  logic        in_flight;

  assign in_flight = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push)
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_i)
        perf_flushed_q <= perf_flushed_q + 32'(cnt_q) + 32'(in_flight && imem_ack_i);
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flushed_o = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (vector table, corner sequences, random vs model)
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        freeze_i = 1'b0;
  logic        valid_o;
  logic [31:0] instr_o, pc_o, pcPlus4_o;
  logic [2:0]  count_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o, perf_flushed_o;
`endif

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .freeze_i(freeze_i), .valid_o(valid_o), .instr_o(instr_o),
    .pc_o(pc_o), .pcPlus4_o(pcPlus4_o), .count_o(count_o)
`ifdef FETCH_PERF_EN
    , .perf_fetched_o(perf_fetched_o), .perf_flushed_o(perf_flushed_o)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Memory responder: one outstanding request, ack after a configurable latency.
  bit          m_pend = 0;
  int          m_left = 0;
  logic [31:0] m_addr = '0;
  int          lat_cfg = 1;
  bit          lat_rand = 0;
  logic        s_req;
  logic [31:0] s_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic settle();
    imem_ack_i  = m_pend && (m_left == 1);
    imem_data_i = imem_ack_i ? memf(m_addr) : $urandom;
    #1;
    s_req  = imem_req_o;
    s_addr = imem_addr_o;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) m_pend = 0;
    else begin
      if (imem_ack_i) m_pend = 0;
      else if (m_pend) m_left--;
      if (s_req) begin
        m_pend = 1;
        m_left = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
        m_addr = s_addr;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; redirect_i = 0; freeze_i = 0;
    repeat (2) begin settle(); advance(); end
    rst = 0;
  endtask

  task automatic check_head(input string nm, input bit ev, input logic [31:0] epc, input int ecnt);
    chk({nm, "_valid"}, 32'(valid_o), 32'(ev));
    chk({nm, "_count"}, 32'(count_o), 32'(ecnt));
    chk({nm, "_pc"},    pc_o,      ev ? epc : 32'h0);
    chk({nm, "_instr"}, instr_o,   ev ? memf(epc) : 32'h0);
    chk({nm, "_pc4"},   pcPlus4_o, ev ? epc + 32'd4 : 32'h0);
  endtask

  task automatic wait_valid(input string nm, input int n);
    bit got = 0;
    for (int i = 0; i < n && !got; i++) begin
      settle();
      if (valid_o) got = 1;
      else advance();
    end
    chk({nm, "_timeout"}, 32'(got), 32'd1);
  endtask

  typedef struct {
    bit rst, frz, ck, ereq;
    logic [31:0] eaddr;
    bit ev;
    logic [31:0] epc;
    int ecnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit f, input bit ck, input bit ereq,
                     input logic [31:0] ea, input bit ev, input logic [31:0] epc, input int ec);
    vec_t v;
    v.rst = r; v.frz = f; v.ck = ck; v.ereq = ereq;
    v.eaddr = ea; v.ev = ev; v.epc = epc; v.ecnt = ec;
    tbl.push_back(v);
  endtask

  // Reference model: fetched entries as a queue plus the fetch PC and one outstanding-request note.
  typedef struct { logic [31:0] pc, ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] mfpc;
  bit          m_out, m_want;
  logic [31:0] pf, pl;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Sequence A: free-running, 1-cycle memory.
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(0,0,1, 1,32'h100, 0,0,0);
    add(0,0,1, 0,0,       0,0,0);
    add(0,0,1, 1,32'h104, 1,32'h100,1);
    add(0,0,1, 0,0,       0,0,0);
    add(0,0,1, 1,32'h108, 1,32'h104,1);
    add(0,0,1, 0,0,       0,0,0);
    add(0,0,1, 1,32'h10C, 1,32'h108,1);
    // Sequence B: freeze until full, then drain in order.
    add(1,0,0, 0,0, 0,0,0);
    add(1,0,0, 0,0, 0,0,0);
    add(0,1,1, 1,32'h100, 0,0,0);
    add(0,1,1, 0,0,       0,0,0);
    add(0,1,1, 1,32'h104, 1,32'h100,1);
    add(0,1,1, 0,0,       1,32'h100,1);
    add(0,1,1, 1,32'h108, 1,32'h100,2);
    add(0,1,1, 0,0,       1,32'h100,2);
    add(0,1,1, 1,32'h10C, 1,32'h100,3);
    add(0,1,1, 0,0,       1,32'h100,3);
    for (int i = 0; i < 12; i++) add(0,1,1, 0,0, 1,32'h100,4);
    add(0,0,1, 0,0,       1,32'h100,4);
    add(0,0,1, 1,32'h110, 1,32'h104,3);
    add(0,0,1, 0,0,       1,32'h108,2);
    add(0,0,1, 1,32'h114, 1,32'h10C,2);
    add(0,0,1, 0,0,       1,32'h110,1);

    lat_cfg = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; freeze_i = tbl[i].frz; redirect_i = 0;
      settle();
      if (tbl[i].ck) begin
        chk($sformatf("tbl%0d_req", i), 32'(imem_req_o), 32'(tbl[i].ereq));
        if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].eaddr);
        check_head($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ecnt);
      end
      advance();
    end

    // Redirect while WAIT, 3-cycle memory: in-flight response dropped.
    lat_cfg = 3; do_reset(); freeze_i = 1;
    settle(); chk("h1_req0", 32'(imem_req_o), 1); chk("h1_addr0", imem_addr_o, 32'h100); advance();
    redirect_i = 1; redirect_pc_i = 32'h203;
    settle(); chk("h1_req_wait", 32'(imem_req_o), 0); advance();
    redirect_i = 0;
    settle(); check_head("h1_drop", 0, 0, 0); chk("h1_req_drop", 32'(imem_req_o), 0); advance();
    settle(); chk("h1_req_dropack", 32'(imem_req_o), 0); advance();
    settle(); chk("h1_req_new", 32'(imem_req_o), 1); chk("h1_addr_new", imem_addr_o, 32'h200); advance();
    wait_valid("h1_first", 10);
    check_head("h1_first", 1, 32'h200, 1); advance();

    // Redirect coincident with ack and pop.
    lat_cfg = 1; do_reset(); freeze_i = 1;
    repeat (3) begin settle(); advance(); end
    freeze_i = 0; redirect_i = 1; redirect_pc_i = 32'h300;
    settle(); chk("h2_ack", 32'(imem_ack_i), 1); check_head("h2_pre", 1, 32'h100, 1); advance();
    redirect_i = 0;
    settle(); check_head("h2_post", 0, 0, 0);
    chk("h2_req", 32'(imem_req_o), 1); chk("h2_addr", imem_addr_o, 32'h300); advance();
    wait_valid("h2_first", 10);
    check_head("h2_first", 1, 32'h300, 1); advance();

    // PC wrap at the top of the address space; target low bits ignored.
    do_reset(); freeze_i = 1;
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFF;
    settle(); chk("h3_req_sup", 32'(imem_req_o), 0); advance();
    redirect_i = 0;
    settle(); chk("h3_req", 32'(imem_req_o), 1); chk("h3_addr", imem_addr_o, 32'hFFFF_FFFC); advance();
    settle(); advance();
    settle(); check_head("h3_head", 1, 32'hFFFF_FFFC, 1);
    chk("h3_req_next", 32'(imem_req_o), 1); chk("h3_addr_next", imem_addr_o, 32'h0); advance();

    // Reset in the cycle a slow response arrives.
    lat_cfg = 1; do_reset(); freeze_i = 1;
    repeat (6) begin settle(); advance(); end
    lat_cfg = 3;
    settle();
`ifdef FETCH_PERF_EN
    chk("h4_perf_pre", perf_fetched_o, 32'd3);
`endif
    advance();
    repeat (2) begin settle(); advance(); end
    rst = 1;
    settle(); chk("h4_ack_in_rst", 32'(imem_ack_i), 1); advance();
    rst = 0;
    settle(); check_head("h4_post", 0, 0, 0);
    chk("h4_req", 32'(imem_req_o), 1); chk("h4_addr", imem_addr_o, RST_PC);
`ifdef FETCH_PERF_EN
    chk("h4_perf_fetched", perf_fetched_o, 32'd0);
    chk("h4_perf_flushed", perf_flushed_o, 32'd0);
`endif
    advance();

    // Random stimulus against the reference model.
    do_reset();
    lat_rand = 1;
    mq.delete(); mfpc = RST_PC; m_out = 0; m_want = 0; pf = 0; pl = 0;
    for (int c = 0; c < 3000; c++) begin
      bit exp_req;
      rst           = ($urandom_range(0, 199) == 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      redirect_pc_i = $urandom;
      freeze_i      = ($urandom_range(0, 9) < 4);
      settle();
      exp_req = !rst && !m_out && !redirect_i && (mq.size() < DEPTH);
      chk("rnd_req", 32'(imem_req_o), 32'(exp_req));
      if (exp_req) chk("rnd_addr", imem_addr_o, mfpc);
      if (mq.size() > 0) begin
        chk("rnd_valid", 32'(valid_o), 1);
        chk("rnd_pc", pc_o, mq[0].pc);
        chk("rnd_instr", instr_o, mq[0].ins);
        chk("rnd_pc4", pcPlus4_o, mq[0].pc + 32'd4);
      end else begin
        chk("rnd_valid", 32'(valid_o), 0);
      end
      chk("rnd_count", 32'(count_o), 32'(mq.size()));
`ifdef FETCH_PERF_EN
      chk("rnd_perf_fetched", perf_fetched_o, pf);
      chk("rnd_perf_flushed", perf_flushed_o, pl);
`endif
      if (rst) begin
        mq.delete(); mfpc = RST_PC; m_out = 0; pf = 0; pl = 0;
      end else if (redirect_i) begin
        pl = pl + 32'(mq.size()) + 32'(m_out && imem_ack_i);
        mq.delete();
        mfpc = redirect_pc_i & ~32'd3;
        if (m_out && !imem_ack_i) m_want = 0;
        else m_out = 0;
      end else begin
        if (mq.size() > 0 && !freeze_i) void'(mq.pop_front());
        if (m_out && imem_ack_i) begin
          if (m_want) begin
            ent_t e;
            e.pc = mfpc; e.ins = imem_data_i;
            mq.push_back(e);
            mfpc = mfpc + 32'd4;
            pf = pf + 32'd1;
          end
          m_out = 0;
        end else if (exp_req) begin
          m_out = 1; m_want = 1;
        end
      end
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
